// File: rtl/my_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor now,
// serial adder/comparator later).
package my_serial_subtractor_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    // Bit counter width: ceil(log2(w)), never below one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/my_serial_subtractor_fadder.sv
// Single-bit full-adder cell shared by the arithmetic library.
module My_fadder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/my_serial_subtractor.sv
// Bit-serial two's-complement subtractor D = A - B, LSB first, one bit per clock,
// built from one full-adder cell with inverted B and carry seeded to 1.
module my_serial_subtractor
    import my_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             V,
    output logic             Z
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   sd_q, sd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               c_q, c_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               bo_q, bo_d;
    logic               v_q, v_d;
    logic               z_q, z_d;
    logic               done_q, done_d;

    logic               bit_s;
    logic               bit_co;
    logic [WIDTH-1:0]   sd_shift;

    My_fadder u_fadder (
        .a_i  (sa_q[0]),
        .b_i  (~sb_q[0]),
        .c_i  (c_q),
        .s_o  (bit_s),
        .co_o (bit_co)
    );

    assign sd_shift = {bit_s, sd_q[WIDTH-1:1]};

    always_comb begin
        // NOTE: every _d takes its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sd_d    = sd_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        d_d     = d_q;
        bo_d    = bo_q;
        v_d     = v_q;
        z_d     = z_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = A;
                    sb_d    = B;
                    sd_d    = '0;
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1];
                    c_d     = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sd_d  = sd_shift;
                c_d   = bit_co;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // Last bit: the result word is sd_shift, its MSB is this cycle's sum bit.
                    state_d = IDLE;
                    cnt_d   = '0;
                    d_d     = sd_shift;
                    bo_d    = ~bit_co;
                    v_d     = (a_msb_q != b_msb_q) & (bit_s != a_msb_q);
                    z_d     = (sd_shift == '0);
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all update together at the edge.
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b1;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            d_q     <= '0;
            bo_q    <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sd_q    <= sd_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            d_q     <= d_d;
            bo_q    <= bo_d;
            v_q     <= v_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign D    = d_q;
    assign Bo   = bo_q;
    assign V    = v_q;
    assign Z    = z_q;

endmodule

// File: tb/tb_my_serial_subtractor.sv
// Self-checking bench for my_serial_subtractor (WIDTH=4): directed handshake
// cases, exhaustive operand sweep and randomized traffic against an arithmetic model.
module tb_my_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         Bo;
    logic         V;
    logic         Z;

    int checks = 0;
    int errors = 0;

    my_serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bo    (Bo),
        .V     (V),
        .Z     (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    task automatic model(input int a, input int b,
                         output int d, output int bo, output int v, output int z);
        int sa;
        int sb;
        int r;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        r  = sa - sb;
        d  = (a - b) & ((1 << W) - 1);
        bo = (a < b) ? 1 : 0;
        v  = (r < -(1 << (W - 1)) || r > (1 << (W - 1)) - 1) ? 1 : 0;
        z  = (d == 0) ? 1 : 0;
    endtask

    task automatic check_result(input string tag, input int a, input int b);
        int d, bo, v, z;
        model(a, b, d, bo, v, z);
        check({tag, ".D"},  32'(D),  32'(d));
        check({tag, ".Bo"}, 32'(Bo), 32'(bo));
        check({tag, ".V"},  32'(V),  32'(v));
        check({tag, ".Z"},  32'(Z),  32'(z));
    endtask

    // Counts falling edges until done is seen (bounded); n is the count at done.
    task automatic wait_done(output int n, output int busy_cycles);
        n = 0;
        busy_cycles = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) busy_cycles++;
        end while (!done && n < 20);
    endtask

    // Drive start for one accepting edge, then scramble A/B to prove capture.
    task automatic issue(input int a, input int b);
        start = 1'b1;
        A = W'(a);
        B = W'(b);
        @(posedge clk);
        #1;
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
    endtask

    task automatic run_op(input string tag, input int a, input int b);
        int n, bc;
        @(negedge clk);
        issue(a, b);
        wait_done(n, bc);
        check({tag, ".latency"}, 32'(n), 32'(W + 1));
        check({tag, ".busy_cycles"}, 32'(bc), 32'(W));
        check_result(tag, a, b);
    endtask

    initial begin
        int n, bc, seen;

        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(posedge clk);
        start = 1'b1;
        @(negedge clk);
        check("reset.busy", 32'(busy), 0);
        check("reset.done", 32'(done), 0);
        check("reset.flags", 32'({D, Bo, V, Z}), 0);
        @(posedge clk);
        #1;
        check("reset_beats_start.busy", 32'(busy), 0);
        start = 1'b0;
        rst = 1'b0;

        // Directed arithmetic cases.
        run_op("sub_9_3", 9, 3);
        check("sub_9_3.D_const", 32'(D), 6);
        run_op("sub_3_9", 3, 9);
        check("sub_3_9.V_const", 32'(V), 1);
        run_op("sub_5_5", 5, 5);
        check("sub_5_5.Z_const", 32'(Z), 1);
        run_op("sub_0_1", 0, 1);
        run_op("sub_8_1", 8, 1);
        check("sub_8_1.V_const", 32'(V), 1);

        // start mid-RUN is ignored and not queued.
        @(negedge clk);
        issue(9, 3);
        @(negedge clk);
        @(negedge clk);
        issue(1, 1);
        wait_done(n, bc);
        check("midrun.latency", 32'(n), 3);
        check_result("midrun", 9, 3);
        @(negedge clk);
        check("midrun.no_queue_busy", 32'(busy), 0);
        check("midrun.done_single", 32'(done), 0);

        // start in the done cycle: accepted with no bubble.
        @(negedge clk);
        issue(4, 1);
        wait_done(n, bc);
        check("b2b_first.latency", 32'(n), W + 1);
        check_result("b2b_first", 4, 1);
        issue(7, 2);
        wait_done(n, bc);
        check("b2b_second.latency", 32'(n), W + 1);
        check("b2b_second.D_const", 32'(D), 5);
        check_result("b2b_second", 7, 2);

        // Reset mid-RUN aborts the operation.
        run_op("pre_abort", 9, 3);
        @(negedge clk);
        issue(12, 5);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort.busy", 32'(busy), 0);
        check("abort.done", 32'(done), 0);
        check("abort.outputs", 32'({D, Bo, V, Z}), 0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort.no_done", 32'(seen), 0);

        // Exhaustive sweep, back-to-back.
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                run_op($sformatf("ex_%0d_%0d", a, b), a, b);
            end
        end

        // Randomized traffic with idle gaps and stray mid-run start pulses.
        for (int i = 0; i < 60; i++) begin
            int a, b, gap;
            a = int'($urandom_range((1 << W) - 1, 0));
            b = int'($urandom_range((1 << W) - 1, 0));
            gap = int'($urandom_range(3, 0));
            repeat (gap) @(negedge clk);
            @(negedge clk);
            issue(a, b);
            if ($urandom_range(1, 0) == 1) begin
                @(negedge clk);
                issue(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
                wait_done(n, bc);
                check($sformatf("rnd%0d.latency", i), 32'(n), W);
            end else begin
                wait_done(n, bc);
                check($sformatf("rnd%0d.latency", i), 32'(n), W + 1);
            end
            check_result($sformatf("rnd%0d", i), a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
